// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: shared state encoding, widths and byte-lane helper for the instruction loader
package inst_loader_pkg;
    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {S_LEN, S_DATA, S_FIN, S_ERR} state_t;

    // Little-endian lanes: each new byte enters at the top and older bytes shift down,
    // so after four bytes the first one sits in bits [7:0].
    function automatic logic [WORD_W-1:0] push_lane(logic [WORD_W-1:0] w, logic [BYTE_W-1:0] b);
        return {b, w[WORD_W-1:BYTE_W]};
    endfunction
endpackage

// File: rtl/inst_loader_byte_packer.sv
// inst_loader_byte_packer: assembles four accepted bytes into a little-endian word
//   clk, rst    : clock, synchronous active-high reset (drops any partial word)
//   en          : a byte transfer happens this cycle
//   data        : the byte being transferred
//   word        : assembled word including the current byte
//   word_valid  : en on the 4th byte of a word; word is complete this cycle
module inst_loader_byte_packer
    import inst_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [BYTE_W-1:0] data,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);
    logic [1:0]        byte_cnt;
    logic [WORD_W-1:0] sr;

    assign word       = push_lane(sr, data);
    assign word_valid = en && (byte_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= 2'd0;
            sr       <= '0;
        end else if (en) begin
            byte_cnt <= byte_cnt + 2'd1;
            sr       <= push_lane(sr, data);
        end
    end
endmodule

// File: rtl/inst_loader.sv
// inst_loader: boot-time byte-stream loader that writes instruction memory and releases the core
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : byte stream handshake, in_data carries the byte
//   mem_we/addr/wd    : one-cycle word write into instruction memory
//   cpu_rst           : holds the core in reset until the program is loaded
//   done, err         : sticky load-complete and oversize-header flags
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [WORD_W-1:0] mem_wd,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);
    state_t            state;
    logic [31:0]       word_idx;
    logic [31:0]       len;
    logic [WORD_W-1:0] word;
    logic              word_valid;
    logic              xfer;

    assign xfer = in_valid && in_ready;

    inst_loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .en         (xfer),
        .data       (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_LEN;
            word_idx <= '0;
            len      <= '0;
            in_ready <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= BASE_ADDR;
            mem_wd   <= '0;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_LEN: if (word_valid) begin
                    len <= word;
                    if (word == '0) begin
                        state    <= S_FIN;
                        in_ready <= 1'b0;
                    end else if (word > 32'(DEPTH_WORDS)) begin
                        state    <= S_ERR;
                        in_ready <= 1'b0;
                        err      <= 1'b1;
                    end else begin
                        state <= S_DATA;
                    end
                end
                S_DATA: if (word_valid) begin
                    mem_we   <= 1'b1;
                    mem_wd   <= word;
                    mem_addr <= BASE_ADDR + (word_idx << 2);
                    word_idx <= word_idx + 32'd1;
                    if (word_idx == len - 32'd1) begin
                        state    <= S_FIN;
                        in_ready <= 1'b0;
                    end
                end
                // Release one cycle after entering S_FIN so the final write lands first.
                S_FIN: begin
                    done    <= 1'b1;
                    cpu_rst <= 1'b0;
                end
                default: err <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed self-checking bench for inst_loader
module tb_inst_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        va = 1'b0, vb = 1'b0;
    logic [7:0]  da = '0, db = '0;
    logic        ra, wea, cra, dna, era;
    logic        rb, web, crb, dnb, erb;
    logic [31:0] adda, wda, addb, wdb;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] la_addr[$], la_wd[$], lb_addr[$], lb_wd[$];

    always #5 clk = ~clk;

    inst_loader dut_a (
        .clk(clk), .rst(rst), .in_valid(va), .in_data(da), .in_ready(ra),
        .mem_we(wea), .mem_addr(adda), .mem_wd(wda), .cpu_rst(cra), .done(dna), .err(era)
    );

    inst_loader #(.DEPTH_WORDS(4), .BASE_ADDR(32'h100)) dut_b (
        .clk(clk), .rst(rst), .in_valid(vb), .in_data(db), .in_ready(rb),
        .mem_we(web), .mem_addr(addb), .mem_wd(wdb), .cpu_rst(crb), .done(dnb), .err(erb)
    );

    always @(posedge clk) begin
        #1;
        if (wea) begin
            la_addr.push_back(adda);
            la_wd.push_back(wda);
        end
        if (web) begin
            lb_addr.push_back(addb);
            lb_wd.push_back(wdb);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        va = 1'b0;
        vb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        la_addr.delete(); la_wd.delete(); lb_addr.delete(); lb_wd.delete();
    endtask

    task automatic send_a(input logic [7:0] d);
        @(negedge clk);
        va = 1'b1;
        da = d;
    endtask

    task automatic send_b(input logic [7:0] d);
        @(negedge clk);
        vb = 1'b1;
        db = d;
    endtask

    task automatic idle_a();
        @(negedge clk);
        va = 1'b0;
    endtask

    task automatic idle_b();
        @(negedge clk);
        vb = 1'b0;
    endtask

    task automatic word_a(input logic [31:0] w);
        for (int j = 0; j < 4; j++) send_a(w[8*j +: 8]);
    endtask

    task automatic word_b(input logic [31:0] w);
        for (int j = 0; j < 4; j++) send_b(w[8*j +: 8]);
    endtask

    initial begin
        do_reset();
        check("rst_ready", 32'(ra), 32'd1);
        check("rst_cpu_rst", 32'(cra), 32'd1);
        check("rst_done", 32'(dna), 32'd0);
        check("rst_err", 32'(era), 32'd0);
        check("rst_we", 32'(wea), 32'd0);
        check("rst_addr_a", adda, 32'h0);
        check("rst_wd", wda, 32'h0);
        check("rst_addr_b", addb, 32'h100);

        word_a(32'd2);
        word_a(32'hDEADBEEF);
        word_a(32'h12345678);
        idle_a();
        check("norm_we2", 32'(wea), 32'd1);
        check("norm_addr2", adda, 32'h4);
        check("norm_wd2", wda, 32'h12345678);
        check("norm_ready_fin", 32'(ra), 32'd0);
        check("norm_done_early", 32'(dna), 32'd0);
        check("norm_cpu_rst_early", 32'(cra), 32'd1);
        idle_a();
        check("norm_done", 32'(dna), 32'd1);
        check("norm_cpu_rst", 32'(cra), 32'd0);
        check("norm_we_low", 32'(wea), 32'd0);
        check("norm_addr_hold", adda, 32'h4);
        check("norm_wd_hold", wda, 32'h12345678);
        check("norm_count", 32'(la_addr.size()), 32'd2);
        check("norm_w0_addr", la_addr[0], 32'h0);
        check("norm_w0_data", la_wd[0], 32'hDEADBEEF);
        check("norm_w1_addr", la_addr[1], 32'h4);
        check("norm_w1_data", la_wd[1], 32'h12345678);

        for (int i = 0; i < 4; i++) send_a(8'h55);
        idle_a();
        check("fin_ignore_count", 32'(la_addr.size()), 32'd2);
        check("fin_ignore_done", 32'(dna), 32'd1);

        do_reset();
        word_a(32'd0);
        idle_a();
        check("zero_done_early", 32'(dna), 32'd0);
        check("zero_ready", 32'(ra), 32'd0);
        idle_a();
        check("zero_done", 32'(dna), 32'd1);
        check("zero_cpu_rst", 32'(cra), 32'd0);
        check("zero_count", 32'(la_addr.size()), 32'd0);

        do_reset();
        word_a(32'd1);
        send_a(8'hEF); idle_a(); idle_a();
        check("thr_idle_ready", 32'(ra), 32'd1);
        check("thr_idle_we", 32'(wea), 32'd0);
        send_a(8'hBE); idle_a(); idle_a();
        send_a(8'hAD); idle_a(); idle_a();
        check("thr_idle_count", 32'(la_addr.size()), 32'd0);
        send_a(8'hDE);
        idle_a();
        check("thr_we", 32'(wea), 32'd1);
        check("thr_addr", adda, 32'h0);
        check("thr_wd", wda, 32'hDEADBEEF);
        idle_a();
        check("thr_done", 32'(dna), 32'd1);
        check("thr_count", 32'(la_addr.size()), 32'd1);

        do_reset();
        word_a(32'd1);
        send_a(8'hAA);
        send_a(8'hBB);
        @(negedge clk);
        rst = 1'b1;
        va = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rmid_cpu_rst", 32'(cra), 32'd1);
        check("rmid_ready", 32'(ra), 32'd1);
        check("rmid_count0", 32'(la_addr.size()), 32'd0);
        word_a(32'd1);
        word_a(32'h44332211);
        idle_a();
        idle_a();
        check("rmid_count", 32'(la_addr.size()), 32'd1);
        check("rmid_addr", la_addr[0], 32'h0);
        check("rmid_data", la_wd[0], 32'h44332211);
        check("rmid_done", 32'(dna), 32'd1);

        do_reset();
        word_b(32'd5);
        send_b(8'hFF);
        check("ovr_err", 32'(erb), 32'd1);
        check("ovr_ready", 32'(rb), 32'd0);
        send_b(8'hFF);
        send_b(8'hFF);
        check("ovr_err_hold", 32'(erb), 32'd1);
        check("ovr_cpu_rst", 32'(crb), 32'd1);
        check("ovr_done", 32'(dnb), 32'd0);
        check("ovr_we", 32'(web), 32'd0);
        check("ovr_count", 32'(lb_addr.size()), 32'd0);

        do_reset();
        word_b(32'd4);
        for (int k = 0; k < 4; k++) word_b(32'hA0B0C0D0 + 32'(k));
        idle_b();
        check("bnd_we", 32'(web), 32'd1);
        check("bnd_last_addr", addb, 32'h10C);
        check("bnd_err", 32'(erb), 32'd0);
        idle_b();
        check("bnd_done", 32'(dnb), 32'd1);
        check("bnd_cpu_rst", 32'(crb), 32'd0);
        check("bnd_count", 32'(lb_addr.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bnd_addr%0d", k), lb_addr[k], 32'h100 + 32'(4 * k));
            check($sformatf("bnd_data%0d", k), lb_wd[k], 32'hA0B0C0D0 + 32'(k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Boot-time writer for the instruction memory; the processor core is the reader of that memory.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word through the instruction memory's write port.
- Holds the core in reset until the whole program is loaded, then releases it.

Parameters:
- DEPTH_WORDS, 1024, instruction memory capacity in words; the maximum legal program length.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word-aligned.

Ports:
- clk  input  1  system clock; everything is sampled on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  source presents a byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid and in_ready are both 1 at a rising edge.
- mem_we  output  1  one-cycle write strobe to instruction memory.
- mem_addr  output  32  byte address of the write; always word-aligned.
- mem_wd  output  32  write data.
- cpu_rst  output  1  reset to the core; 1 while loading.
- done  output  1  load finished successfully; sticky until rst.
- err  output  1  length header exceeded DEPTH_WORDS; sticky until rst.

Behaviour:
- Reset values: state=S_LEN, byte_cnt=0, word_idx=0, len=0.
- Output reset values: mem_we=0, mem_addr=BASE_ADDR, mem_wd=0, cpu_rst=1, done=0, err=0, in_ready=1 from the first cycle after reset.
- Stream format: a 4-byte length N (word count), then N words of 4 bytes each. All fields are little-endian: the first byte goes to bits [7:0], the fourth to bits [31:24].
- byte_cnt (2 bits) advances only on a transfer and wraps 3->0.
- S_LEN: in_ready=1. On the 4th header byte, latch len:
  - len==0 -> S_FIN.
  - len>DEPTH_WORDS -> S_ERR.
  - otherwise -> S_DATA.
- S_DATA: in_ready=1. On the 4th byte of a word:
  - Next cycle: mem_we=1 for exactly one cycle, mem_wd=assembled word, mem_addr=BASE_ADDR + 4*word_idx.
  - word_idx then increments.
  - If this was word len-1, go to S_FIN; otherwise stay in S_DATA.
- Throughput: one byte per cycle. A write strobe overlaps acceptance of the next word's bytes; no stall is ever inserted.
- S_FIN: in_ready=0. Entered in the same cycle as the final mem_we pulse, or immediately after the header when len==0. On the next cycle, done=1 and cpu_rst=0; both hold until rst. This ordering guarantees the last write completes before the core leaves reset.
- S_ERR: in_ready=0, err=1, cpu_rst stays 1, mem_we stays 0. Stuck until rst.
- Idle input (in_valid=0): no state change. Partial words and partial headers are held indefinitely.
- mem_addr and mem_wd hold their last values when mem_we=0.
- Reset mid-load: returns to S_LEN and discards any partial word. Memory already written is not touched. cpu_rst reasserts on the cycle after rst is sampled; rst takes priority over every other transition.
- Bytes offered in S_FIN or S_ERR are not accepted, since in_ready=0.
- len==DEPTH_WORDS is legal. The last address written is BASE_ADDR + 4*(DEPTH_WORDS-1).

Decomposition:
- Shared package holds:
  - state encoding typedef: S_LEN, S_DATA, S_FIN, S_ERR.
  - WORD_W=32 and BYTE_W=8 constants.
  - the little-endian byte-lane convention.
- One natural sub-module: byte_packer, which shifts four accepted bytes into a 32-bit word and flags word_valid on the 4th byte. It is reused for both the length header and data words. The FSM, address counter and release logic stay in inst_loader.

Test Plan:
- Normal load: bytes 02 00 00 00, EF BE AD DE, 78 56 34 12 on consecutive cycles -> two mem_we pulses: 0x0000_0000<=0xDEADBEEF, then 0x0000_0004<=0x12345678. done=1 and cpu_rst=0 on the cycle after the second pulse.
- Zero length: 00 00 00 00 -> no mem_we. done=1 and cpu_rst=0 two cycles after the 4th byte is accepted.
- Oversize: with DEPTH_WORDS=4, send header 05 00 00 00 -> err=1, in_ready=0, cpu_rst=1, no writes, even while in_valid stays high.
- Throttled source: load of 1 word with in_valid toggled 1,0,0,1,... -> identical data and address to the unthrottled case; nothing happens during idle cycles.
- Reset mid-word: header 01 00 00 00, data AA BB, then rst for one cycle, then 01 00 00 00, 11 22 33 44 -> a single write 0x0000_0000<=0x44332211; AA and BB are never written.
- Boundary: DEPTH_WORDS=4, BASE_ADDR=0x100, len=4 -> writes to 0x100, 0x104, 0x108, 0x10C, then done=1.
